// File: rtl/proposed_model_pkg.sv
// ----------------------------------------------------------------------------
// proposed_model_pkg
//
// Purpose:
//   Shared defaults and helpers for the binary-weight fully connected layer
//   (proposed_model_w_bin) and its per-neuron datapath (bin_neuron).
//
// Contents:
//   INPUT_DIM_DEF   default number of input activations per vector
//   OUTPUT_DIM_DEF  default number of output neurons
//   BIT_CNT_DEF     default activation word width (signed, in and out)
//   acc_w()         width of the signed accumulator for a given layer shape
//   sat_to_bitcnt() clamps a signed sum into the signed range of bit_cnt bits
// ----------------------------------------------------------------------------
package proposed_model_pkg;

    localparam int INPUT_DIM_DEF  = 16;
    localparam int OUTPUT_DIM_DEF = 8;
    localparam int BIT_CNT_DEF    = 8;

    // Accumulator width: one activation word, plus log2(INPUT_DIM) bits of
    // growth for the sum, plus one extra bit so that negating the most
    // negative activation can never overflow.
    function automatic int acc_w(input int bit_cnt, input int input_dim);
        return bit_cnt + $clog2(input_dim) + 1;
    endfunction

    // Clamp a signed sum to the representable range of a bit_cnt-wide
    // two's complement word. In-range values pass through untouched.
    function automatic int sat_to_bitcnt(input int acc, input int bit_cnt);
        int maxVal;
        int minVal;
        maxVal = (1 << (bit_cnt - 1)) - 1;
        minVal = -(1 << (bit_cnt - 1));
        if (acc > maxVal) begin
            return maxVal;
        end else if (acc < minVal) begin
            return minVal;
        end else begin
            return acc;
        end
    endfunction

endpackage

// File: rtl/proposed_model_w_bin_bin_neuron.sv
// ----------------------------------------------------------------------------
// bin_neuron
//
// Purpose:
//   One output neuron of a binary-weight fully connected layer. Every input
//   activation is either added or subtracted depending on its weight bit,
//   the signed terms are summed in a balanced adder tree and the result is
//   saturated back to the activation word width. Purely combinational; the
//   enclosing layer owns the output register.
//
// Ports:
//   value_in    in   [INPUT_DIM][BIT_CNT]  packed activations, element j = x[j]
//   weight_row  in   [INPUT_DIM]           weight bits, 1 => +x[j], 0 => -x[j]
//   value_out   out  [BIT_CNT]             saturated signed neuron result
// ----------------------------------------------------------------------------
module bin_neuron
    import proposed_model_pkg::*;
#(
    parameter int INPUT_DIM = INPUT_DIM_DEF,
    parameter int BIT_CNT   = BIT_CNT_DEF
) (
    input  logic [INPUT_DIM-1:0][BIT_CNT-1:0] value_in,
    input  logic [INPUT_DIM-1:0]              weight_row,
    output logic [BIT_CNT-1:0]                value_out
);

    localparam int ACC_W = acc_w(BIT_CNT, INPUT_DIM);

    // Leaf count of the adder tree, rounded up to a power of two so the
    // reduction below is a perfectly balanced binary tree. Unused leaves
    // are tied to zero and drop out of the sum.
    localparam int PAD = 1 << $clog2(INPUT_DIM);

    logic signed [ACC_W-1:0] w_acc;

    // Build the signed terms and reduce them pairwise. Each pass halves the
    // number of live partial sums, so the loop unrolls into a tree of depth
    // log2(PAD) rather than a linear chain of adders. Activations are
    // sign-extended to the full accumulator width before negation, which
    // keeps -(-2^(BIT_CNT-1)) exact.
    always_comb begin
        logic signed [ACC_W-1:0] v [PAD];
        logic signed [ACC_W-1:0] ext;
        for (int i = 0; i < PAD; i++) begin
            v[i] = '0;
        end
        for (int j = 0; j < INPUT_DIM; j++) begin
            ext  = {{(ACC_W - BIT_CNT){value_in[j][BIT_CNT-1]}}, value_in[j]};
            v[j] = weight_row[j] ? ext : -ext;
        end
        for (int width = PAD; width > 1; width = width / 2) begin
            for (int i = 0; i < width / 2; i++) begin
                v[i] = v[2*i] + v[2*i+1];
            end
        end
        w_acc = v[0];
    end

    // The accumulator is sign-extended to int for the shared clamp helper;
    // the clamped value always fits in BIT_CNT bits, so the narrowing cast
    // keeps exactly the meaningful bits.
    assign value_out = BIT_CNT'(sat_to_bitcnt(int'(w_acc), BIT_CNT));

endmodule

// File: rtl/proposed_model_w_bin.sv
// ----------------------------------------------------------------------------
// proposed_model_w_bin
//
// Purpose:
//   Fully connected layer with binary weights for the BinaryNet datapath.
//   Each output neuron is the saturated signed sum of all inputs, where each
//   weight bit selects +x or -x. Results are registered once, giving a fixed
//   one-cycle latency and a throughput of one vector per cycle. There is no
//   handshake: a new input vector and weight set may arrive every cycle.
//
// Ports:
//   clk        in   1                         rising-edge clock
//   rst        in   1                         synchronous, active-high reset
//   value_in   in   [INPUT_DIM][BIT_CNT]      packed activations, element j = x[j]
//   weight     in   [OUTPUT_DIM][INPUT_DIM]   weight[o][j]: 1 => +1, 0 => -1
//   value_out  out  [OUTPUT_DIM][BIT_CNT]     registered outputs, element o = y[o]
// ----------------------------------------------------------------------------
module proposed_model_w_bin
    import proposed_model_pkg::*;
#(
    parameter int INPUT_DIM  = INPUT_DIM_DEF,
    parameter int OUTPUT_DIM = OUTPUT_DIM_DEF,
    parameter int BIT_CNT    = BIT_CNT_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [INPUT_DIM-1:0][BIT_CNT-1:0]   value_in,
    input  logic [OUTPUT_DIM-1:0][INPUT_DIM-1:0] weight,
    output logic [OUTPUT_DIM-1:0][BIT_CNT-1:0]  value_out
);

    logic [OUTPUT_DIM-1:0][BIT_CNT-1:0] w_neuronOut;
    logic [OUTPUT_DIM-1:0][BIT_CNT-1:0] r_valueOut;

    // One independent combinational neuron per output, all fed from the
    // same activation vector and each given its own row of weight bits.
    for (genvar o = 0; o < OUTPUT_DIM; o++) begin : gen_neuron
        bin_neuron #(
            .INPUT_DIM (INPUT_DIM),
            .BIT_CNT   (BIT_CNT)
        ) u_neuron (
            .value_in   (value_in),
            .weight_row (weight[o]),
            .value_out  (w_neuronOut[o])
        );
    end

    // Single pipeline register across the whole layer. Reset clears every
    // output so nothing undefined leaks downstream; otherwise the register
    // simply captures the current neuron results every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valueOut <= '0;
        end else begin
            r_valueOut <= w_neuronOut;
        end
    end

    assign value_out = r_valueOut;

endmodule

// File: tb/tb_proposed_model_w_bin.sv
// ----------------------------------------------------------------------------
// tb_proposed_model_w_bin
//
// Directed and randomized checks of the binary-weight fully connected layer.
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// 1 time unit after the following rising edge, i.e. one cycle later.
// ----------------------------------------------------------------------------
module tb_proposed_model_w_bin;

    localparam int IN_DIM  = 16;
    localparam int OUT_DIM = 8;
    localparam int BITS    = 8;

    logic                           clk;
    logic                           rst;
    logic [IN_DIM-1:0][BITS-1:0]    valueIn;
    logic [OUT_DIM-1:0][IN_DIM-1:0] weight;
    logic [OUT_DIM-1:0][BITS-1:0]   valueOut;

    int checkCount;
    int errorCount;

    proposed_model_w_bin #(
        .INPUT_DIM  (IN_DIM),
        .OUTPUT_DIM (OUT_DIM),
        .BIT_CNT    (BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value_in  (valueIn),
        .weight    (weight),
        .value_out (valueOut)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference neuron: literal per-term sum in plain integers, then clamp.
    function automatic int modelNeuron(input logic [IN_DIM-1:0][BITS-1:0] x,
                                       input logic [IN_DIM-1:0] w);
        int acc;
        int xv;
        acc = 0;
        for (int j = 0; j < IN_DIM; j++) begin
            xv = int'($signed(x[j]));
            if (w[j]) acc = acc + xv;
            else      acc = acc - xv;
        end
        if (acc > 127)  acc = 127;
        if (acc < -128) acc = -128;
        return acc;
    endfunction

    // Single comparison point; every check funnels through here.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one input set and advance one clock, leaving the bench 1 time
    // unit past the edge that captured those inputs.
    task automatic applyStimulus(input logic [IN_DIM-1:0][BITS-1:0] x,
                                 input logic [OUT_DIM-1:0][IN_DIM-1:0] w,
                                 input logic r);
        valueIn = x;
        weight  = w;
        rst     = r;
        @(posedge clk);
        #1;
    endtask

    // Compare every output element against the model of the given inputs.
    task automatic checkAgainstModel(input string tag,
                                     input logic [IN_DIM-1:0][BITS-1:0] x,
                                     input logic [OUT_DIM-1:0][IN_DIM-1:0] w);
        for (int o = 0; o < OUT_DIM; o++) begin
            checkOutput($sformatf("%s_y%0d", tag, o), int'($signed(valueOut[o])),
                        modelNeuron(x, w[o]));
        end
    endtask

    task automatic checkAllEqual(input string tag, input int expected);
        for (int o = 0; o < OUT_DIM; o++) begin
            checkOutput($sformatf("%s_y%0d", tag, o), int'($signed(valueOut[o])), expected);
        end
    endtask

    initial begin
        logic [IN_DIM-1:0][BITS-1:0]    x;
        logic [OUT_DIM-1:0][IN_DIM-1:0] w;

        checkCount = 0;
        errorCount = 0;
        rst        = 1'b1;
        valueIn    = '0;
        weight     = '0;
        #1;

        // T1: reset held two cycles, then released with zero activations.
        applyStimulus('0, '0, 1'b1);
        applyStimulus('0, '0, 1'b1);
        checkAllEqual("t1_reset", 0);
        applyStimulus('0, '0, 1'b0);
        checkAllEqual("t1_release", 0);

        // T2: all x=1, row0 all +1, row1 all -1, others mixed.
        for (int j = 0; j < IN_DIM; j++) x[j] = 8'd1;
        w = '0;
        w[0] = 16'hFFFF;
        w[1] = 16'h0000;
        w[2] = 16'h00FF;
        w[3] = 16'h0001;
        applyStimulus(x, w, 1'b0);
        checkOutput("t2_y0", int'($signed(valueOut[0])), 16);
        checkOutput("t2_y1", int'($signed(valueOut[1])), -16);
        checkOutput("t2_y2", int'($signed(valueOut[2])), 0);
        checkOutput("t2_y3", int'($signed(valueOut[3])), -14);

        // T3: x[j]=j with alternating weights (odd indices +1) on all rows.
        for (int j = 0; j < IN_DIM; j++) x[j] = BITS'(j);
        for (int o = 0; o < OUT_DIM; o++) w[o] = 16'hAAAA;
        applyStimulus(x, w, 1'b0);
        checkAllEqual("t3_alt", 8);

        // T3b: per-bit sign convention; row o enables only bit 2o+1, so
        // y[o] = 2*(2o+1) - 120 = 4o - 118.
        for (int o = 0; o < OUT_DIM; o++) w[o] = IN_DIM'(1) << (2*o + 1);
        applyStimulus(x, w, 1'b0);
        for (int o = 0; o < OUT_DIM; o++) begin
            checkOutput($sformatf("t3_bit_y%0d", o), int'($signed(valueOut[o])), 4*o - 118);
        end

        // T4: saturation at both rails and exact values at the boundary.
        for (int j = 0; j < IN_DIM; j++) x[j] = 8'sd127;
        applyStimulus(x, '1, 1'b0);
        checkAllEqual("t4_pos_sat", 127);
        for (int j = 0; j < IN_DIM; j++) x[j] = 8'h80;
        applyStimulus(x, '1, 1'b0);
        checkAllEqual("t4_neg_sat", -128);
        applyStimulus(x, '0, 1'b0);
        checkAllEqual("t4_neg_neg", 127);
        x = '0;
        x[0] = 8'h80;
        applyStimulus(x, '1, 1'b0);
        checkAllEqual("t4_edge_min", -128);
        applyStimulus(x, '0, 1'b0);
        checkAllEqual("t4_edge_flip", 127);
        x[0] = 8'h7F;
        applyStimulus(x, '1, 1'b0);
        checkAllEqual("t4_edge_max", 127);

        // T5: twenty back-to-back random vectors and weights.
        for (int n = 0; n < 20; n++) begin
            for (int j = 0; j < IN_DIM; j++) x[j] = BITS'($urandom_range(0, 255));
            for (int o = 0; o < OUT_DIM; o++) w[o] = IN_DIM'($urandom);
            applyStimulus(x, w, 1'b0);
            checkAgainstModel($sformatf("t5_v%0d", n), x, w);
        end

        // T6: reset mid-stream clears the outputs, and the first cycle after
        // release reflects the inputs captured at that edge.
        for (int j = 0; j < IN_DIM; j++) x[j] = BITS'($urandom_range(0, 255));
        for (int o = 0; o < OUT_DIM; o++) w[o] = IN_DIM'($urandom);
        applyStimulus(x, w, 1'b0);
        checkAgainstModel("t6_pre", x, w);
        applyStimulus(x, w, 1'b1);
        checkAllEqual("t6_rst", 0);
        for (int j = 0; j < IN_DIM; j++) x[j] = BITS'($urandom_range(0, 255));
        for (int o = 0; o < OUT_DIM; o++) w[o] = IN_DIM'($urandom);
        applyStimulus(x, w, 1'b0);
        checkAgainstModel("t6_post", x, w);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
